player_motion_ctrl: RTL and testbench

//  Consumes the decoded w_on/a_on/s_on/d_on key levels and moves the player sprite once per video frame.

---
 rtl/party_pkg.sv | 20 ++
 rtl/sync_rise_detect.sv | 28 ++
 rtl/player_motion_ctrl.sv | 119 +++++++++++
 tb/tb_player_motion_ctrl.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/party_pkg.sv
// Shared types and screen geometry for the player sprite pipeline.
package party_pkg;

    typedef enum logic [1:0] {
        UP    = 2'd0,
        DOWN  = 2'd1,
        LEFT  = 2'd2,
        RIGHT = 2'd3
    } dir_t;

    typedef enum logic {
        IDLE = 1'b0,
        WALK = 1'b1
    } motion_state_t;

    localparam int SCREEN_W    = 640;
    localparam int SCREEN_H    = 480;
    localparam int SPRITE_SIZE = 16;

endpackage

// File: rtl/sync_rise_detect.sv
// Brings an asynchronous strobe into the Clk domain and emits a one-cycle
// pulse on its rising edge.
module sync_rise_detect (
    input  logic Clk,
    input  logic Reset_n,
    input  logic async_in,
    output logic pulse
);

    logic meta;
    logic sync;
    logic prev;

    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            meta <= 1'b0;
            sync <= 1'b0;
            prev <= 1'b0;
        end else begin
            meta <= async_in;
            sync <= meta;
            prev <= sync;
        end
    end

    assign pulse = sync & ~prev;

endmodule

// File: rtl/player_motion_ctrl.sv
// Moves the player sprite once per frame tick from the held WASD keys, clamping
// to the screen and driving facing, moving flag and walk-animation phase.
module player_motion_ctrl
    import party_pkg::*;
#(
    parameter int STEP     = 1,
    parameter int X_MIN    = 0,
    parameter int X_MAX    = SCREEN_W - SPRITE_SIZE - 1,
    parameter int Y_MIN    = 0,
    parameter int Y_MAX    = SCREEN_H - SPRITE_SIZE - 1,
    parameter int X_INIT   = 320,
    parameter int Y_INIT   = 240,
    parameter int ANIM_DIV = 8
) (
    input  logic       Clk,
    input  logic       Reset_n,
    input  logic       frame_clk,
    input  logic       w_on,
    input  logic       a_on,
    input  logic       s_on,
    input  logic       d_on,
    output logic [9:0] pos_x,
    output logic [9:0] pos_y,
    output logic [1:0] facing,
    output logic       moving,
    output logic [1:0] step_phase
);

    localparam int CNT_W = (ANIM_DIV > 1) ? $clog2(ANIM_DIV) : 1;
    localparam logic signed [10:0] X_MIN_S = 11'(X_MIN);
    localparam logic signed [10:0] X_MAX_S = 11'(X_MAX);
    localparam logic signed [10:0] Y_MIN_S = 11'(Y_MIN);
    localparam logic signed [10:0] Y_MAX_S = 11'(Y_MAX);
    localparam logic signed [10:0] STEP_S  = 11'(STEP);

    logic               tick;
    motion_state_t      state;
    dir_t               facing_q;
    dir_t               facing_next;
    logic [CNT_W-1:0]   anim_cnt;
    logic signed [10:0] dx;
    logic signed [10:0] dy;
    logic signed [10:0] nx_raw;
    logic signed [10:0] ny_raw;
    logic [9:0]         nx;
    logic [9:0]         ny;
    logic               moved;

    sync_rise_detect u_frame_sync (
        .Clk      (Clk),
        .Reset_n  (Reset_n),
        .async_in (frame_clk),
        .pulse    (tick)
    );

    // Opposing keys cancel; the move is judged on the clamped result so a
    // wall-blocked key counts as no displacement but still turns the sprite.
    always_comb begin
        dx = '0;
        dy = '0;
        if (d_on && !a_on) dx = STEP_S;
        else if (a_on && !d_on) dx = -STEP_S;
        if (s_on && !w_on) dy = STEP_S;
        else if (w_on && !s_on) dy = -STEP_S;

        nx_raw = $signed({1'b0, pos_x}) + dx;
        ny_raw = $signed({1'b0, pos_y}) + dy;

        if (nx_raw < X_MIN_S)      nx = X_MIN_S[9:0];
        else if (nx_raw > X_MAX_S) nx = X_MAX_S[9:0];
        else                       nx = nx_raw[9:0];

        if (ny_raw < Y_MIN_S)      ny = Y_MIN_S[9:0];
        else if (ny_raw > Y_MAX_S) ny = Y_MAX_S[9:0];
        else                       ny = ny_raw[9:0];

        facing_next = facing_q;
        if (dy[10])          facing_next = UP;
        else if (dy != '0)   facing_next = DOWN;
        else if (dx[10])     facing_next = LEFT;
        else if (dx != '0)   facing_next = RIGHT;

        moved = (nx != pos_x) || (ny != pos_y);
    end

    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            pos_x      <= 10'(X_INIT);
            pos_y      <= 10'(Y_INIT);
            facing_q   <= DOWN;
            state      <= IDLE;
            moving     <= 1'b0;
            anim_cnt   <= '0;
            step_phase <= 2'd0;
        end else if (tick) begin
            pos_x    <= nx;
            pos_y    <= ny;
            facing_q <= facing_next;
            if (moved) begin
                state  <= WALK;
                moving <= 1'b1;
                if (anim_cnt == CNT_W'(ANIM_DIV - 1)) begin
                    anim_cnt   <= '0;
                    step_phase <= step_phase + 2'd1;
                end else begin
                    anim_cnt <= anim_cnt + CNT_W'(1);
                end
            end else begin
                state      <= IDLE;
                moving     <= 1'b0;
                anim_cnt   <= '0;
                step_phase <= 2'd0;
            end
        end
    end

    assign facing = facing_q;

endmodule

// File: tb/tb_player_motion_ctrl.sv
// Directed self-checking bench for player_motion_ctrl: reset, walking, key
// cancellation, wall clamping, tick timing and reset during a tick.
module tb_player_motion_ctrl;

    logic       Clk = 1'b0;
    logic       Reset_n;
    logic       frame_clk;
    logic       w_on, a_on, s_on, d_on;
    logic [9:0] pos_x, pos_y;
    logic [1:0] facing;
    logic       moving;
    logic [1:0] step_phase;

    int checks   = 0;
    int failures = 0;

    player_motion_ctrl dut (
        .Clk        (Clk),
        .Reset_n    (Reset_n),
        .frame_clk  (frame_clk),
        .w_on       (w_on),
        .a_on       (a_on),
        .s_on       (s_on),
        .d_on       (d_on),
        .pos_x      (pos_x),
        .pos_y      (pos_y),
        .facing     (facing),
        .moving     (moving),
        .step_phase (step_phase)
    );

    always #5 Clk = ~Clk;

    task automatic set_keys(input logic w, input logic a, input logic s, input logic d);
        w_on = w; a_on = a; s_on = s; d_on = d;
    endtask

    // Drop frame_clk long enough to clear the synchronizer, then raise it and
    // return at the falling edge just after the update edge.
    task automatic do_tick();
        frame_clk = 1'b0;
        repeat (3) @(negedge Clk);
        frame_clk = 1'b1;
        repeat (3) @(negedge Clk);
    endtask

    task automatic test_reset();
        Reset_n   = 1'b0;
        frame_clk = 1'b0;
        set_keys(0, 0, 0, 0);
        repeat (3) @(negedge Clk);
        checks++;
        if (pos_x !== 10'd320 || pos_y !== 10'd240 || facing !== 2'd1 || moving !== 1'b0 || step_phase !== 2'd0) begin
            failures++;
            $display("[TB] FAIL reset_state got x=%0d y=%0d f=%0d m=%0d p=%0d exp x=320 y=240 f=1 m=0 p=0",
                     pos_x, pos_y, facing, moving, step_phase);
        end
        Reset_n = 1'b1;
        do_tick();
        checks++;
        if (pos_x !== 10'd320 || pos_y !== 10'd240 || facing !== 2'd1 || moving !== 1'b0 || step_phase !== 2'd0) begin
            failures++;
            $display("[TB] FAIL idle_tick got x=%0d y=%0d f=%0d m=%0d p=%0d exp x=320 y=240 f=1 m=0 p=0",
                     pos_x, pos_y, facing, moving, step_phase);
        end
    endtask

    task automatic test_walk_right();
        set_keys(0, 0, 0, 1);
        for (int k = 1; k <= 10; k++) begin
            do_tick();
            checks++;
            if (pos_x !== 10'(320 + k) || pos_y !== 10'd240) begin
                failures++;
                $display("[TB] FAIL walk_right_pos tick=%0d got x=%0d y=%0d exp x=%0d y=240", k, pos_x, pos_y, 320 + k);
            end
            if (k == 7 || k == 8) begin
                checks++;
                if (step_phase !== ((k == 8) ? 2'd1 : 2'd0)) begin
                    failures++;
                    $display("[TB] FAIL walk_right_phase tick=%0d got %0d exp %0d", k, step_phase, (k == 8) ? 1 : 0);
                end
            end
        end
        checks++;
        if (facing !== 2'd3 || moving !== 1'b1 || step_phase !== 2'd1) begin
            failures++;
            $display("[TB] FAIL walk_right_flags got f=%0d m=%0d p=%0d exp f=3 m=1 p=1", facing, moving, step_phase);
        end
    endtask

    task automatic test_cancel_up();
        set_keys(1, 1, 0, 1);
        for (int k = 1; k <= 3; k++) begin
            do_tick();
            checks++;
            if (pos_x !== 10'd330 || pos_y !== 10'(240 - k) || facing !== 2'd0 || moving !== 1'b1) begin
                failures++;
                $display("[TB] FAIL cancel_up tick=%0d got x=%0d y=%0d f=%0d m=%0d exp x=330 y=%0d f=0 m=1",
                         k, pos_x, pos_y, facing, moving, 240 - k);
            end
        end
        checks++;
        if (step_phase !== 2'd1) begin
            failures++;
            $display("[TB] FAIL cancel_up_phase got %0d exp 1", step_phase);
        end
    endtask

    task automatic test_right_wall();
        set_keys(0, 0, 0, 1);
        repeat (292) do_tick();
        checks++;
        if (pos_x !== 10'd622) begin
            failures++;
            $display("[TB] FAIL wall_approach got x=%0d exp 622", pos_x);
        end
        do_tick();
        checks++;
        if (pos_x !== 10'd623 || moving !== 1'b1) begin
            failures++;
            $display("[TB] FAIL wall_t1 got x=%0d m=%0d exp x=623 m=1", pos_x, moving);
        end
        do_tick();
        checks++;
        if (pos_x !== 10'd623 || moving !== 1'b0 || step_phase !== 2'd0 || facing !== 2'd3) begin
            failures++;
            $display("[TB] FAIL wall_t2 got x=%0d m=%0d p=%0d f=%0d exp x=623 m=0 p=0 f=3", pos_x, moving, step_phase, facing);
        end
        do_tick();
        checks++;
        if (pos_x !== 10'd623 || moving !== 1'b0 || step_phase !== 2'd0) begin
            failures++;
            $display("[TB] FAIL wall_t3 got x=%0d m=%0d p=%0d exp x=623 m=0 p=0", pos_x, moving, step_phase);
        end
    endtask

    task automatic test_top_wall();
        set_keys(1, 0, 0, 0);
        repeat (237) do_tick();
        checks++;
        if (pos_y !== 10'd0 || moving !== 1'b1) begin
            failures++;
            $display("[TB] FAIL top_reach got y=%0d m=%0d exp y=0 m=1", pos_y, moving);
        end
        do_tick();
        checks++;
        if (pos_y !== 10'd0 || pos_x !== 10'd623 || moving !== 1'b0 || facing !== 2'd0) begin
            failures++;
            $display("[TB] FAIL top_blocked got x=%0d y=%0d m=%0d f=%0d exp x=623 y=0 m=0 f=0", pos_x, pos_y, moving, facing);
        end
    endtask

    task automatic test_tick_timing();
        set_keys(0, 0, 0, 0);
        frame_clk = 1'b0;
        repeat (3) @(negedge Clk);
        set_keys(0, 1, 0, 0);
        frame_clk = 1'b1;
        @(negedge Clk);
        set_keys(1, 0, 0, 0);
        @(negedge Clk);
        checks++;
        if (pos_x !== 10'd623 || pos_y !== 10'd0) begin
            failures++;
            $display("[TB] FAIL timing_early got x=%0d y=%0d exp x=623 y=0", pos_x, pos_y);
        end
        set_keys(0, 0, 1, 0);
        @(negedge Clk);
        set_keys(0, 1, 0, 0);
        checks++;
        if (pos_x !== 10'd623 || pos_y !== 10'd1 || facing !== 2'd1 || moving !== 1'b1) begin
            failures++;
            $display("[TB] FAIL timing_update got x=%0d y=%0d f=%0d m=%0d exp x=623 y=1 f=1 m=1", pos_x, pos_y, facing, moving);
        end
        repeat (3) @(negedge Clk);
        set_keys(1, 0, 0, 1);
        repeat (3) @(negedge Clk);
        checks++;
        if (pos_x !== 10'd623 || pos_y !== 10'd1 || facing !== 2'd1) begin
            failures++;
            $display("[TB] FAIL timing_hold got x=%0d y=%0d f=%0d exp x=623 y=1 f=1", pos_x, pos_y, facing);
        end
    endtask

    task automatic test_reset_mid_walk();
        set_keys(0, 1, 0, 0);
        frame_clk = 1'b0;
        repeat (3) @(negedge Clk);
        frame_clk = 1'b1;
        repeat (2) @(negedge Clk);
        Reset_n = 1'b0;
        @(negedge Clk);
        checks++;
        if (pos_x !== 10'd320 || pos_y !== 10'd240 || moving !== 1'b0 || step_phase !== 2'd0 || facing !== 2'd1) begin
            failures++;
            $display("[TB] FAIL reset_in_tick got x=%0d y=%0d m=%0d p=%0d f=%0d exp x=320 y=240 m=0 p=0 f=1",
                     pos_x, pos_y, moving, step_phase, facing);
        end
        frame_clk = 1'b0;
        Reset_n   = 1'b1;
        set_keys(0, 0, 0, 1);
        do_tick();
        checks++;
        if (pos_x !== 10'd321 || pos_y !== 10'd240 || moving !== 1'b1 || step_phase !== 2'd0 || facing !== 2'd3) begin
            failures++;
            $display("[TB] FAIL after_reset_walk got x=%0d y=%0d m=%0d p=%0d f=%0d exp x=321 y=240 m=1 p=0 f=3",
                     pos_x, pos_y, moving, step_phase, facing);
        end
    endtask

    initial begin
        test_reset();
        test_walk_right();
        test_cancel_up();
        test_right_wall();
        test_top_wall();
        test_tick_timing();
        test_reset_mid_walk();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
